// File: rtl/cpu_mem_pkg.sv
// Shared definitions for the instruction/data memory arbiter: FSM states,
// requester identity and default geometry.
package cpu_mem_pkg;

  localparam int MEM_LAT_DEF = 4;
  localparam int AW_DEF      = 16;
  localparam int DW_DEF      = 16;
  localparam int CNT_W       = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } arb_state_e;

  typedef enum logic {
    OWN_FETCH = 1'b0,
    OWN_DATA  = 1'b1
  } owner_e;

endpackage

// File: rtl/mem_lat_cnt.sv
// Memory-latency down-counter: loads a preset, counts down to zero and holds
// there, exposing a zero flag.
module mem_lat_cnt
  import cpu_mem_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic             dec_i,
  output logic             zero_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter between instruction fetch and data access.
// Data requests win over fetch; each access runs IDLE -> ACCESS -> DONE.
module mem_arbiter
  import cpu_mem_pkg::*;
#(
  parameter int MEM_LAT = MEM_LAT_DEF,
  parameter int AW      = AW_DEF,
  parameter int DW      = DW_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_req,
  input  logic [AW-1:0] i_addr,
  output logic          i_rdy,
  output logic [DW-1:0] i_data,
  input  logic          d_re,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_rdy,
  output logic [DW-1:0] d_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          stall_if,
  output logic          stall_mem,
  output logic          err
);

  arb_state_e    state_q;
  owner_e        owner_q;
  logic          mem_en_q, mem_we_q;
  logic [AW-1:0] mem_addr_q;
  logic [DW-1:0] mem_wdata_q;
  logic          i_rdy_q, d_rdy_q;
  logic [DW-1:0] i_data_q, d_rdata_q;
  logic          err_q;

  logic d_req;
  logic grant;
  logic cnt_zero;

  assign d_req = d_re | d_we;
  assign grant = (state_q == ST_IDLE) && (d_req || i_req);

  mem_lat_cnt u_cnt (
    .clk       (clk),
    .rst_n     (rst_n),
    .load_i    (grant),
    .load_val_i(CNT_W'(MEM_LAT - 1)),
    .dec_i     (state_q == ST_ACCESS),
    .zero_o    (cnt_zero)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      owner_q     <= OWN_FETCH;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      i_rdy_q     <= 1'b0;
      d_rdy_q     <= 1'b0;
      i_data_q    <= '0;
      d_rdata_q   <= '0;
      err_q       <= 1'b0;
    end else begin
      i_rdy_q <= 1'b0;
      d_rdy_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (grant) begin
            state_q  <= ST_ACCESS;
            mem_en_q <= 1'b1;
            if (d_req) begin
              // A simultaneous read+write is treated as a write and flagged.
              owner_q     <= OWN_DATA;
              mem_addr_q  <= d_addr;
              mem_wdata_q <= d_wdata;
              mem_we_q    <= d_we;
              if (d_re && d_we) begin
                err_q <= 1'b1;
              end
            end else begin
              owner_q     <= OWN_FETCH;
              mem_addr_q  <= i_addr;
              mem_wdata_q <= '0;
              mem_we_q    <= 1'b0;
            end
          end
        end
        ST_ACCESS: begin
          if (cnt_zero) begin
            state_q  <= ST_DONE;
            mem_en_q <= 1'b0;
            mem_we_q <= 1'b0;
            if (owner_q == OWN_DATA) begin
              d_rdata_q <= mem_rdata;
              d_rdy_q   <= 1'b1;
            end else begin
              i_data_q <= mem_rdata;
              i_rdy_q  <= 1'b1;
            end
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign i_rdy     = i_rdy_q;
  assign d_rdy     = d_rdy_q;
  assign i_data    = i_data_q;
  assign d_rdata   = d_rdata_q;
  assign err       = err_q;

  assign stall_if  = i_req & ~i_rdy_q;
  assign stall_mem = d_req & ~d_rdy_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus randomized traffic checked
// against a transaction-window reference model.
module tb_mem_arbiter;
  import cpu_mem_pkg::*;

  localparam int LAT = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, i_req, d_re, d_we;
  logic [15:0] i_addr, d_addr, d_wdata, mem_rdata;

  logic        i_rdy, d_rdy, mem_en, mem_we, stall_if, stall_mem, err;
  logic [15:0] i_data, d_rdata, mem_addr, mem_wdata;

  logic        i_rdy1, d_rdy1, mem_en1, mem_we1, stall_if1, stall_mem1, err1;
  logic [15:0] i_data1, d_rdata1, mem_addr1, mem_wdata1;

  mem_arbiter #(.MEM_LAT(LAT), .AW(16), .DW(16)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .i_req(i_req), .i_addr(i_addr), .i_rdy(i_rdy), .i_data(i_data),
    .d_re(d_re), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdy(d_rdy), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .stall_if(stall_if), .stall_mem(stall_mem), .err(err)
  );

  mem_arbiter #(.MEM_LAT(1), .AW(16), .DW(16)) u_dut1 (
    .clk(clk), .rst_n(rst_n),
    .i_req(i_req), .i_addr(i_addr), .i_rdy(i_rdy1), .i_data(i_data1),
    .d_re(d_re), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdy(d_rdy1), .d_rdata(d_rdata1),
    .mem_en(mem_en1), .mem_we(mem_we1), .mem_addr(mem_addr1),
    .mem_wdata(mem_wdata1), .mem_rdata(mem_rdata),
    .stall_if(stall_if1), .stall_mem(stall_mem1), .err(err1)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Reference model: each grant opens an access window [g+1, g+LAT], a
  // completion at g+LAT+1, and the arbiter is free again at g+LAT+2.
  bit          model_on = 0;
  int          free_at = 0, acc_s = -10, acc_e = -10, done_c = -10;
  bit          m_own_d = 0, m_we = 0, e_err = 0;
  logic [15:0] m_addr = '0, m_wdata = '0, e_idata = '0, e_ddata = '0;

  task automatic model_step();
    bit en, exp_ir, exp_dr;
    if (model_on) begin
      en     = (cyc >= acc_s) && (cyc <= acc_e);
      exp_ir = (cyc == done_c) && !m_own_d;
      exp_dr = (cyc == done_c) && m_own_d;
      chk("m_mem_en", 32'(mem_en), 32'(en));
      chk("m_mem_we", 32'(mem_we), 32'(en && m_we));
      if (en) begin
        chk("m_mem_addr", 32'(mem_addr), 32'(m_addr));
        if (m_we) chk("m_mem_wdata", 32'(mem_wdata), 32'(m_wdata));
      end
      chk("m_i_rdy", 32'(i_rdy), 32'(exp_ir));
      chk("m_d_rdy", 32'(d_rdy), 32'(exp_dr));
      chk("m_i_data", 32'(i_data), 32'(e_idata));
      chk("m_d_rdata", 32'(d_rdata), 32'(e_ddata));
      chk("m_err", 32'(err), 32'(e_err));
      chk("m_stall_if", 32'(stall_if), 32'(i_req && !exp_ir));
      chk("m_stall_mem", 32'(stall_mem), 32'((d_re || d_we) && !exp_dr));
    end
    if (!rst_n) begin
      model_on = 1;
      free_at  = cyc + 1;
      acc_s    = -10;
      acc_e    = -10;
      done_c   = -10;
      e_idata  = '0;
      e_ddata  = '0;
      e_err    = 0;
    end else if (model_on) begin
      if (cyc == acc_e) begin
        if (m_own_d) e_ddata = mem_rdata;
        else         e_idata = mem_rdata;
      end
      if ((cyc >= free_at) && (i_req || d_re || d_we)) begin
        m_own_d = d_re || d_we;
        m_addr  = m_own_d ? d_addr : i_addr;
        m_we    = m_own_d && d_we;
        m_wdata = d_wdata;
        if (d_re && d_we) e_err = 1;
        acc_s   = cyc + 1;
        acc_e   = cyc + LAT;
        done_c  = cyc + LAT + 1;
        free_at = cyc + LAT + 2;
      end
    end
  endtask

  task automatic sample();
    @(negedge clk);
    model_step();
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle_cycles(input int n);
    for (int j = 0; j < n; j++) begin
      sample();
      adv();
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bit li, ld;
    int unsigned r;
    rst_n = 1'b0; i_req = 1'b0; d_re = 1'b0; d_we = 1'b0;
    i_addr = '0; d_addr = '0; d_wdata = '0; mem_rdata = '0;
    idle_cycles(2);
    rst_n = 1'b1;
    sample();
    chk("rst_mem_addr", 32'(mem_addr), 32'h0);
    chk("rst_mem_wdata", 32'(mem_wdata), 32'h0);
    chk("rst_state", 32'(u_dut.state_q), 32'(ST_IDLE));
    adv();
    idle_cycles(2);

    // Single fetch, MEM_LAT=4
    i_req = 1'b1; i_addr = 16'h0010; mem_rdata = 16'hA5A5;
    for (int k = 0; k < 8; k++) begin
      if (k == 6) i_req = 1'b0;
      sample();
      chk("A_mem_en", 32'(mem_en), 32'(k >= 1 && k <= 4));
      if (k >= 1 && k <= 4) chk("A_mem_addr", 32'(mem_addr), 32'h0010);
      chk("A_i_rdy", 32'(i_rdy), 32'(k == 5));
      if (k == 5) chk("A_i_data", 32'(i_data), 32'hA5A5);
      adv();
    end

    // Data beats fetch when both rise together
    i_req = 1'b1; i_addr = 16'h0044; d_re = 1'b1; d_addr = 16'h0200;
    for (int k = 0; k < 14; k++) begin
      if (k == 6) d_re = 1'b0;
      if (k == 12) i_req = 1'b0;
      mem_rdata = (k < 6) ? 16'h1111 : 16'h2222;
      sample();
      chk("B_d_rdy", 32'(d_rdy), 32'(k == 5));
      chk("B_i_rdy", 32'(i_rdy), 32'(k == 11));
      if (k >= 1 && k <= 4) chk("B_daddr", 32'(mem_addr), 32'h0200);
      if (k == 6) chk("B_gap_en", 32'(mem_en), 32'h0);
      if (k >= 7 && k <= 10) begin
        chk("B_f_en", 32'(mem_en), 32'h1);
        chk("B_iaddr", 32'(mem_addr), 32'h0044);
      end
      if (k == 5) chk("B_d_rdata", 32'(d_rdata), 32'h1111);
      if (k == 11) chk("B_i_data", 32'(i_data), 32'h2222);
      adv();
    end

    // Data write
    d_we = 1'b1; d_addr = 16'h0300; d_wdata = 16'h1234;
    for (int k = 0; k < 8; k++) begin
      if (k == 6) d_we = 1'b0;
      sample();
      chk("C_mem_we", 32'(mem_we), 32'(k >= 1 && k <= 4));
      if (k >= 1 && k <= 4) begin
        chk("C_mem_addr", 32'(mem_addr), 32'h0300);
        chk("C_mem_wdata", 32'(mem_wdata), 32'h1234);
      end
      chk("C_d_rdy", 32'(d_rdy), 32'(k == 5));
      chk("C_i_rdy", 32'(i_rdy), 32'h0);
      adv();
    end

    // Reset in the middle of a fetch, then the held request is re-served
    i_req = 1'b1; i_addr = 16'h0077; mem_rdata = 16'h3C3C;
    for (int k = 0; k < 10; k++) begin
      rst_n = (k == 2) ? 1'b0 : 1'b1;
      if (k == 9) i_req = 1'b0;
      sample();
      if (k == 3) begin
        chk("D_en_after_rst", 32'(mem_en), 32'h0);
        chk("D_state_idle", 32'(u_dut.state_q), 32'(ST_IDLE));
      end
      if (k >= 4 && k <= 7) chk("D_reissue_en", 32'(mem_en), 32'h1);
      chk("D_i_rdy", 32'(i_rdy), 32'(k == 8));
      if (k == 8) chk("D_i_data", 32'(i_data), 32'h3C3C);
      adv();
    end

    // MEM_LAT=1 instance under continuous fetch
    rst_n = 1'b0;
    idle_cycles(1);
    rst_n = 1'b1; i_req = 1'b1; i_addr = 16'h0088;
    for (int k = 0; k < 13; k++) begin
      if (k == 12) i_req = 1'b0;
      sample();
      if (k < 12) begin
        chk("F_i_rdy1", 32'(i_rdy1), 32'((k % 3) == 2));
        chk("F_stall_if1", 32'(stall_if1), 32'((k % 3) != 2));
      end
      adv();
    end
    idle_cycles(8);

    // Read and write together: performed as a write, err is sticky
    d_re = 1'b1; d_we = 1'b1; d_addr = 16'h0400; d_wdata = 16'hBEEF;
    for (int k = 0; k < 16; k++) begin
      if (k == 6) begin d_re = 1'b0; d_we = 1'b0; end
      if (k == 7) begin i_req = 1'b1; i_addr = 16'h0099; end
      if (k == 13) i_req = 1'b0;
      sample();
      if (k >= 1 && k <= 4) begin
        chk("E_mem_we", 32'(mem_we), 32'h1);
        chk("E_mem_wdata", 32'(mem_wdata), 32'hBEEF);
      end
      chk("E_err", 32'(err), 32'(k >= 1));
      adv();
    end
    rst_n = 1'b0;
    idle_cycles(1);
    rst_n = 1'b1;
    sample();
    chk("E_err_cleared", 32'(err), 32'h0);
    adv();

    // Randomized traffic, requesters hold until their rdy pulse
    li = 0; ld = 0;
    for (int n = 0; n < 3000; n++) begin
      rst_n     = ($urandom_range(0, 299) != 0);
      mem_rdata = 16'($urandom);
      if (!(i_req && !li)) begin
        i_req  = 1'($urandom_range(0, 1));
        i_addr = 16'($urandom);
      end else if ($urandom_range(0, 3) == 0) begin
        i_addr = 16'($urandom);
      end
      if (!((d_re || d_we) && !ld)) begin
        r       = $urandom_range(0, 39);
        d_re    = (r <= 9) || (r == 39);
        d_we    = (r >= 10 && r <= 17) || (r == 39);
        d_addr  = 16'($urandom);
        d_wdata = 16'($urandom);
      end
      sample();
      li = i_rdy;
      ld = d_rdy;
      adv();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
